// File: rtl/mips_multicycle_control_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// The controller drives the strobes; the datapath drives opcode, funct, flags and memory handshake.
interface mips_multicycle_control_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic [2:0] alusel;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic [3:0] state;

  modport master (
    input  op, funct, zero, mem_ready,
    output alusel, alusrca, alusrcb, pcsrc, pcen, iord, memwrite,
           irwrite, regdst, memtoreg, regwrite, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  alusel, alusrca, alusrcb, pcsrc, pcen, iord, memwrite,
           irwrite, regdst, memtoreg, regwrite, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Moore control FSM for a multicycle MIPS core (lw/sw/R-type/beq/addi/j).
// 2-5 cycles per instruction; mem_ready=0 stalls FETCH/MEMRD/MEMWR one cycle at a time.
module mips_multicycle_control (
  input  logic                      clk,
  input  logic                      rst_n,
  mips_multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  typedef struct packed {
    logic [2:0] alusel;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       fetch;
    logic       branch;
    logic       pcwrite;
    logic       use_funct;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOP = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   fetch_go;
  logic   pcwrite;

  // Per-state strobes; the fetch handshake, funct decode and branch condition are overlaid later.
  function automatic ctrl_t decode(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alusel  = ALU_ADD;
        c.alusrcb = 2'b01;
        c.fetch   = 1'b1;
      end
      S_DECODE: begin
        c.alusel  = ALU_ADD;
        c.alusrcb = 2'b11;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alusel  = ALU_ADD;
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        c.alusrca   = 1'b1;
        c.use_funct = 1'b1;
      end
      S_RTYPEWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BEQEX: begin
        c.alusel  = ALU_SUB;
        c.alusrca = 1'b1;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      S_ADDIWB: c.regwrite = 1'b1;
      S_JEX: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return ALU_ADD;
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      default:   return ALU_NOP;
    endcase
  endfunction

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      // Writeback/terminal states and any stray encoding all return to FETCH.
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d);
    end
  end

  assign fetch_go = ctrl_q.fetch & bus.mem_ready;
  assign pcwrite  = ctrl_q.pcwrite | fetch_go;

  assign bus.alusel   = ctrl_q.use_funct ? funct_alu(bus.funct) : ctrl_q.alusel;
  assign bus.alusrca  = ctrl_q.alusrca;
  assign bus.alusrcb  = ctrl_q.alusrcb;
  assign bus.pcsrc    = ctrl_q.pcsrc;
  assign bus.pcen     = pcwrite | (ctrl_q.branch & bus.zero);
  assign bus.iord     = ctrl_q.iord;
  assign bus.memwrite = ctrl_q.memwrite;
  assign bus.irwrite  = fetch_go;
  assign bus.regdst   = ctrl_q.regdst;
  assign bus.memtoreg = ctrl_q.memtoreg;
  assign bus.regwrite = ctrl_q.regwrite;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed vector bench for the multicycle MIPS control FSM.
// Expected word: {state, alusel, alusrca, alusrcb, pcsrc, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite}.
module tb_mips_multicycle_control;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  mips_multicycle_control_if bus ();

  mips_multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [18:0] E_FETCH1 = {4'd0, 3'b010, 1'b0, 2'b01, 2'b00, 7'b1001000};
  localparam logic [18:0] E_FETCH0 = {4'd0, 3'b010, 1'b0, 2'b01, 2'b00, 7'b0000000};
  localparam logic [18:0] E_DEC    = {4'd1, 3'b010, 1'b0, 2'b11, 2'b00, 7'b0000000};
  localparam logic [18:0] E_MA     = {4'd2, 3'b010, 1'b1, 2'b10, 2'b00, 7'b0000000};
  localparam logic [18:0] E_MRD    = {4'd3, 3'b000, 1'b0, 2'b00, 2'b00, 7'b0100000};
  localparam logic [18:0] E_MWB    = {4'd4, 3'b000, 1'b0, 2'b00, 2'b00, 7'b0000011};
  localparam logic [18:0] E_MWR    = {4'd5, 3'b000, 1'b0, 2'b00, 2'b00, 7'b0110000};
  localparam logic [18:0] E_RWB    = {4'd7, 3'b000, 1'b0, 2'b00, 2'b00, 7'b0000101};
  localparam logic [18:0] E_AEX    = {4'd9, 3'b010, 1'b1, 2'b10, 2'b00, 7'b0000000};
  localparam logic [18:0] E_AWB    = {4'd10, 3'b000, 1'b0, 2'b00, 2'b00, 7'b0000001};
  localparam logic [18:0] E_JEX    = {4'd11, 3'b000, 1'b0, 2'b00, 2'b10, 7'b1000000};

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  function automatic logic [18:0] e_rx(input logic [2:0] sel);
    return {4'd6, sel, 1'b1, 2'b00, 2'b00, 7'b0000000};
  endfunction

  function automatic logic [18:0] e_beq(input logic z);
    return {4'd8, 3'b110, 1'b1, 2'b00, 2'b01, z, 6'b000000};
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mr;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] funct,
                              input logic zero, input logic mr, input logic [18:0] exp);
    vec_t v;
    v.op = op; v.funct = funct; v.zero = zero; v.mr = mr; v.exp = exp;
    return v;
  endfunction

  function automatic logic [18:0] actual();
    return {bus.state, bus.alusel, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.pcen,
            bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg, bus.regwrite};
  endfunction

  task automatic check(input string nm, input logic [18:0] exp);
    logic [18:0] act;
    act = actual();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %05h expected %05h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] funct, input logic z, input logic mr);
    bus.op = op;
    bus.funct = funct;
    bus.zero = z;
    bus.mem_ready = mr;
  endtask

  // One clock cycle: drive, settle, compare, advance past the next rising edge.
  task automatic cyc(input string nm, input logic [5:0] op, input logic [5:0] funct,
                     input logic z, input logic mr, input logic [18:0] exp);
    drive(op, funct, z, mr);
    #1;
    check(nm, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;

    // R-type with each funct code; junk op outside DECODE/RTYPEEX must be ignored.
    tbl.push_back(mk(OP_BAD, 6'h00, 1'b1, 1'b1, E_FETCH1));
    tbl.push_back(mk(OP_R,   6'h2a, 1'b1, 1'b1, E_DEC));
    tbl.push_back(mk(OP_R,   6'h2a, 1'b1, 1'b1, e_rx(3'b111)));
    tbl.push_back(mk(OP_LW,  6'h00, 1'b1, 1'b1, E_RWB));
    tbl.push_back(mk(OP_R,   6'h00, 1'b0, 1'b1, E_FETCH1));
    tbl.push_back(mk(OP_R,   6'h22, 1'b0, 1'b1, E_DEC));
    tbl.push_back(mk(OP_R,   6'h22, 1'b0, 1'b1, e_rx(3'b110)));
    tbl.push_back(mk(OP_R,   6'h22, 1'b0, 1'b1, E_RWB));
    tbl.push_back(mk(OP_R,   6'h24, 1'b0, 1'b1, E_FETCH1));
    tbl.push_back(mk(OP_R,   6'h24, 1'b0, 1'b1, E_DEC));
    tbl.push_back(mk(OP_R,   6'h24, 1'b0, 1'b1, e_rx(3'b000)));
    tbl.push_back(mk(OP_R,   6'h24, 1'b0, 1'b1, E_RWB));
    tbl.push_back(mk(OP_R,   6'h25, 1'b0, 1'b1, E_FETCH1));
    tbl.push_back(mk(OP_R,   6'h25, 1'b0, 1'b1, E_DEC));
    tbl.push_back(mk(OP_R,   6'h25, 1'b0, 1'b1, e_rx(3'b001)));
    tbl.push_back(mk(OP_R,   6'h25, 1'b0, 1'b1, E_RWB));
    tbl.push_back(mk(OP_R,   6'h20, 1'b0, 1'b1, E_FETCH1));
    tbl.push_back(mk(OP_R,   6'h20, 1'b0, 1'b1, E_DEC));
    tbl.push_back(mk(OP_R,   6'h20, 1'b0, 1'b1, e_rx(3'b010)));
    tbl.push_back(mk(OP_R,   6'h20, 1'b0, 1'b1, E_RWB));
    tbl.push_back(mk(OP_R,   6'h3f, 1'b0, 1'b1, E_FETCH1));
    tbl.push_back(mk(OP_R,   6'h3f, 1'b0, 1'b1, E_DEC));
    tbl.push_back(mk(OP_R,   6'h3f, 1'b0, 1'b1, e_rx(3'b011)));
    tbl.push_back(mk(OP_R,   6'h3f, 1'b0, 1'b1, E_RWB));
    // beq taken then not taken
    tbl.push_back(mk(OP_BEQ, 6'h00, 1'b0, 1'b1, E_FETCH1));
    tbl.push_back(mk(OP_BEQ, 6'h00, 1'b1, 1'b1, E_DEC));
    tbl.push_back(mk(OP_BEQ, 6'h00, 1'b1, 1'b1, e_beq(1'b1)));
    tbl.push_back(mk(OP_BEQ, 6'h00, 1'b0, 1'b1, E_FETCH1));
    tbl.push_back(mk(OP_BEQ, 6'h00, 1'b0, 1'b1, E_DEC));
    tbl.push_back(mk(OP_BEQ, 6'h00, 1'b0, 1'b1, e_beq(1'b0)));
    // addi, j
    tbl.push_back(mk(OP_ADDI, 6'h00, 1'b0, 1'b1, E_FETCH1));
    tbl.push_back(mk(OP_ADDI, 6'h00, 1'b0, 1'b1, E_DEC));
    tbl.push_back(mk(OP_ADDI, 6'h00, 1'b1, 1'b1, E_AEX));
    tbl.push_back(mk(OP_SW,   6'h00, 1'b1, 1'b1, E_AWB));
    tbl.push_back(mk(OP_J,    6'h00, 1'b0, 1'b1, E_FETCH1));
    tbl.push_back(mk(OP_J,    6'h00, 1'b0, 1'b1, E_DEC));
    tbl.push_back(mk(OP_J,    6'h00, 1'b1, 1'b1, E_JEX));
    // lw and sw without stalls
    tbl.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b1, E_FETCH1));
    tbl.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b1, E_DEC));
    tbl.push_back(mk(OP_LW, 6'h00, 1'b0, 1'b1, E_MA));
    tbl.push_back(mk(OP_LW, 6'h00, 1'b1, 1'b1, E_MRD));
    tbl.push_back(mk(OP_BAD, 6'h00, 1'b1, 1'b1, E_MWB));
    tbl.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b1, E_FETCH1));
    tbl.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b1, E_DEC));
    tbl.push_back(mk(OP_SW, 6'h00, 1'b0, 1'b1, E_MA));
    tbl.push_back(mk(OP_SW, 6'h00, 1'b1, 1'b1, E_MWR));
    // illegal opcode, then a fetch stalled two cycles
    tbl.push_back(mk(OP_BAD, 6'h00, 1'b1, 1'b1, E_FETCH1));
    tbl.push_back(mk(OP_BAD, 6'h00, 1'b1, 1'b1, E_DEC));
    tbl.push_back(mk(OP_BAD, 6'h00, 1'b1, 1'b0, E_FETCH0));
    tbl.push_back(mk(OP_BAD, 6'h00, 1'b1, 1'b0, E_FETCH0));
    tbl.push_back(mk(OP_BAD, 6'h00, 1'b1, 1'b1, E_FETCH1));
    tbl.push_back(mk(OP_BAD, 6'h00, 1'b1, 1'b1, E_DEC));

    // Reset asserted while the clock runs.
    drive(OP_BAD, 6'h00, 1'b0, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("reset_state", E_FETCH1);
    drive(OP_BAD, 6'h00, 1'b0, 1'b0);
    #1;
    check("reset_gated", E_FETCH0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      cyc($sformatf("vec%0d", i), tbl[i].op, tbl[i].funct, tbl[i].zero, tbl[i].mr, tbl[i].exp);

    // lw with MEMRD stalled three cycles: state 3 for four cycles.
    cyc("lw_f",    OP_LW, 6'h00, 1'b0, 1'b1, E_FETCH1);
    cyc("lw_d",    OP_LW, 6'h00, 1'b0, 1'b1, E_DEC);
    cyc("lw_ma",   OP_LW, 6'h00, 1'b0, 1'b1, E_MA);
    cyc("lw_rd0",  OP_LW, 6'h00, 1'b0, 1'b0, E_MRD);
    cyc("lw_rd1",  OP_LW, 6'h00, 1'b1, 1'b0, E_MRD);
    cyc("lw_rd2",  OP_LW, 6'h00, 1'b0, 1'b0, E_MRD);
    cyc("lw_rd3",  OP_LW, 6'h00, 1'b0, 1'b1, E_MRD);
    cyc("lw_wb",   OP_LW, 6'h00, 1'b0, 1'b1, E_MWB);

    // sw with MEMWR stalled two cycles: memwrite held three cycles.
    cyc("sw_f",    OP_SW, 6'h00, 1'b0, 1'b1, E_FETCH1);
    cyc("sw_d",    OP_SW, 6'h00, 1'b0, 1'b1, E_DEC);
    cyc("sw_ma",   OP_SW, 6'h00, 1'b0, 1'b1, E_MA);
    cyc("sw_wr0",  OP_SW, 6'h00, 1'b0, 1'b0, E_MWR);
    cyc("sw_wr1",  OP_SW, 6'h00, 1'b1, 1'b0, E_MWR);
    cyc("sw_wr2",  OP_SW, 6'h00, 1'b0, 1'b1, E_MWR);
    cyc("sw_done", OP_BAD, 6'h00, 1'b0, 1'b0, E_FETCH0);
    cyc("sw_next", OP_BAD, 6'h00, 1'b0, 1'b1, E_FETCH1);

    // Asynchronous reset in the middle of a stalled store.
    cyc("rst_d",   OP_SW, 6'h00, 1'b0, 1'b1, E_DEC);
    cyc("rst_ma",  OP_SW, 6'h00, 1'b0, 1'b1, E_MA);
    drive(OP_SW, 6'h00, 1'b0, 1'b0);
    #1;
    check("rst_pre_wr", E_MWR);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", E_FETCH0);
    @(posedge clk);
    #1;
    check("rst_hold", E_FETCH0);
    rst_n = 1'b1;
    cyc("rec_f",   OP_R, 6'h2a, 1'b0, 1'b1, E_FETCH1);
    cyc("rec_d",   OP_R, 6'h2a, 1'b0, 1'b1, E_DEC);
    cyc("rec_rx",  OP_R, 6'h2a, 1'b0, 1'b1, e_rx(3'b111));
    cyc("rec_wb",  OP_R, 6'h2a, 1'b0, 1'b1, E_RWB);
    cyc("rec_end", OP_R, 6'h2a, 1'b0, 1'b1, E_FETCH1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 SHALL have no parameters; all widths fixed as listed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 op  in  6  instruction opcode from instruction register, instr[31:26].
REQ-005 funct  in  6  R-type function field, instr[5:0].
REQ-006 zero  in  1  ALU zero flag (1 when ALU result == 0).
REQ-007 mem_ready  in  1  memory handshake; 1 = current fetch/read/write completes this cycle.
REQ-008 alusel  out  3  ALU operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 = unsupported (ALU yields 0).
REQ-009 alusrca  out  1  ALU A select: 0 PC, 1 register A.
REQ-010 alusrcb  out  2  ALU B select: 00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-011 pcsrc  out  2  next-PC select: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-012 pcen  out  1  PC write enable.
REQ-013 iord  out  1  memory address select: 0 PC, 1 ALUOut.
REQ-014 memwrite  out  1  memory write strobe.
REQ-015 irwrite  out  1  instruction register load.
REQ-016 regdst  out  1  dest register: 0 rt, 1 rd.
REQ-017 memtoreg  out  1  writeback data: 0 ALUOut, 1 memory data.
REQ-018 regwrite  out  1  register file write enable.
REQ-019 state  out  4  current state encoding, debug.

Function
REQ-020 SHALL implement a Moore FSM, states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11; codes 12-15 unreachable, recover to FETCH next edge.
REQ-021 Transitions: FETCH->DECODE when mem_ready=1, else stay; DECODE->MEMADR (op 100011 lw / 101011 sw), RTYPEEX (000000), BEQEX (000100), ADDIEX (001000), JEX (000010), FETCH (any other op).
REQ-022 MEMADR->MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB when mem_ready=1, else stay; MEMWR->FETCH when mem_ready=1, else stay; MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX->FETCH; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB.
REQ-023 All outputs not listed for a state SHALL be 0 (alusel 000, alusrcb 00, pcsrc 00).
REQ-024 FETCH: iord=0, alusrca=0, alusrcb=01, alusel=010, pcsrc=00, irwrite=mem_ready, pcwrite=mem_ready.
REQ-025 DECODE: alusrca=0, alusrcb=11, alusel=010 (branch target precompute).
REQ-026 MEMADR and ADDIEX: alusrca=1, alusrcb=10, alusel=010.
REQ-027 MEMRD: iord=1; MEMWR: iord=1, memwrite=1 held for every cycle in state; MEMWB: memtoreg=1, regwrite=1, regdst=0.
REQ-028 RTYPEEX: alusrca=1, alusrcb=00, alusel from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->011.
REQ-029 RTYPEWB: regdst=1, memtoreg=0, regwrite=1; ADDIWB: regdst=0, memtoreg=0, regwrite=1.
REQ-030 BEQEX: alusrca=1, alusrcb=00, alusel=110, pcsrc=01, branch=1; JEX: pcsrc=10, pcwrite=1.
REQ-031 pcen SHALL equal pcwrite OR (branch AND zero), combinational; only output depending on an input other than state/op/funct/mem_ready.
REQ-032 Latency with mem_ready tied 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3, illegal op 2.
REQ-033 Each cycle mem_ready=0 in FETCH/MEMRD/MEMWR SHALL add exactly one cycle; outputs stay at state values except FETCH irwrite/pcwrite held 0.
REQ-034 op/funct SHALL be ignored outside DECODE, MEMADR, RTYPEEX.

Reset
REQ-035 rst_n=0 SHALL force state=FETCH immediately, independent of clk, aborting any instruction mid-flight.
REQ-036 During reset all outputs SHALL show FETCH values with mem_ready gating (regwrite=0, memwrite=0).
REQ-037 First state change after rst_n rises SHALL occur on first rising clk edge with rst_n=1.

Verification
REQ-038 op=000000, funct=101010, mem_ready=1 -> states 0,1,6,7,0; alusel=111 in RTYPEEX; regwrite=1, regdst=1 in RTYPEWB only.
REQ-039 op=000100, zero=1 in BEQEX -> pcen=1, pcsrc=01; repeat with zero=0 -> pcen=0, back to FETCH.
REQ-040 op=100011, mem_ready=0 for 3 cycles in MEMRD -> state 3 held 4 cycles, iord=1 throughout, then MEMWB with memtoreg=1.
REQ-041 op=101011, mem_ready=0 for 2 cycles in MEMWR -> memwrite=1 for 3 cycles, no regwrite, return to FETCH.
REQ-042 op=111111 -> FETCH, DECODE, FETCH; no regwrite/memwrite/pcen pulse beyond FETCH.
REQ-043 rst_n low mid-MEMWR between clk edges -> state=0, memwrite=0 immediately; recovers normal fetch after release.
